// File: rtl/pipeline_pkg.sv
// Shared pipeline constants used by the fetch stage and, later, by the
// ID/EX latches.
//   NOP_INSTR : instruction word inserted as a bubble
//   PC_INC    : byte increment between sequential instructions
//   WORD_W    : datapath / instruction width
package pipeline_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  // Force a byte address onto a word boundary.
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_mem.sv
// Instruction ROM with a combinational read port.
// The array contents are supplied by the environment (for example written
// directly by a testbench); MEM_FILE is retained as a parameter for
// interface compatibility.
// Ports:
//   addr : word index [ADDR_W-1:0]
//   data : instruction word at addr
module instr_mem
    import pipeline_pkg::*;
#(
    parameter int MEM_DEPTH = 128,
    parameter int ADDR_W = 7,
    parameter string MEM_FILE = "instr.mem"
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] data
);

    logic [WORD_W-1:0] mem [MEM_DEPTH];

    assign data = mem[addr];

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: holds the PC, reads the instruction ROM and
// registers {instruction, npc, valid} for the IF/ID latch.
// A taken branch from MEM flushes the wrong-path fetch with one bubble.
// A branch arriving during a stall is remembered and applied on the first
// unstalled cycle.
// Ports:
//   clk, rst        : clock (rising edge), synchronous active-high reset
//   stall           : hold PC and outputs this cycle
//   pc_src          : branch taken, redirect to branch_target
//   branch_target   : redirect byte address (low two bits ignored)
//   pc_out          : current fetch PC
//   instruction_out : fetched instruction (to IF/ID instruction_in)
//   npc_out         : fetched PC + 4 (to IF/ID npc_in)
//   valid_out       : 1 = real instruction, 0 = bubble
module if_fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int MEM_DEPTH = 128,
  parameter int ADDR_W = 7,
  parameter string MEM_FILE = "instr.mem"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic        valid_out
);

  logic [31:0] pc_reg;
  logic [31:0] instr_reg;
  logic [31:0] npc_reg;
  logic        valid_reg;
  logic        redirect_pending_reg;
  logic [31:0] saved_target_reg;

  logic [31:0] mem_word;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] target;

  // Word index wraps modulo MEM_DEPTH; upper PC bits are ignored.
  instr_mem #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_W   (ADDR_W),
    .MEM_FILE (MEM_FILE)
  ) u_mem (
    .addr(pc_reg[ADDR_W+1:2]),
    .data(mem_word)
  );

  assign pc_plus4 = pc_reg + PC_INC;
  assign redirect = pc_src || redirect_pending_reg;
  // A live branch takes priority over one saved during an earlier stall.
  assign target   = pc_src ? word_align(branch_target) : saved_target_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg               <= RESET_PC;
      instr_reg            <= NOP_INSTR;
      npc_reg              <= '0;
      valid_reg            <= 1'b0;
      redirect_pending_reg <= 1'b0;
      saved_target_reg     <= '0;
    end else if (stall) begin
      // Outputs and PC hold; only remember a branch (last one wins).
      if (pc_src) begin
        redirect_pending_reg <= 1'b1;
        saved_target_reg     <= word_align(branch_target);
      end
    end else if (redirect) begin
      pc_reg               <= target;
      instr_reg            <= NOP_INSTR;
      npc_reg              <= '0;
      valid_reg            <= 1'b0;
      redirect_pending_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_plus4;
      instr_reg <= mem_word;
      npc_reg   <= pc_plus4;
      valid_reg <= 1'b1;
    end
  end

  assign pc_out          = pc_reg;
  assign instruction_out = instr_reg;
  assign npc_out         = npc_reg;
  assign valid_out       = valid_reg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. The ROM image is written directly into
// the instance array (MEM_FILE left empty). Inputs change 1 ns after each
// rising edge and outputs are sampled at the same point.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        pc_src;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [31:0] npc_out;
  logic        valid_out;

  int vectors = 0;
  int miscompares = 0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .MEM_DEPTH(128),
    .ADDR_W   (7),
    .MEM_FILE ("")
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .pc_src         (pc_src),
    .branch_target  (branch_target),
    .pc_out         (pc_out),
    .instruction_out(instruction_out),
    .npc_out        (npc_out),
    .valid_out      (valid_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] npc, input logic v);
    chk({tag, ".pc"}, pc_out, pc);
    chk({tag, ".instr"}, instruction_out, ins);
    chk({tag, ".npc"}, npc_out, npc);
    chk({tag, ".valid"}, {31'b0, valid_out}, {31'b0, v});
    $display("%-12s pc=%h instr=%h npc=%h valid=%0b", tag, pc_out, instruction_out, npc_out, valid_out);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) dut.u_mem.mem[i] = 32'h0;
    dut.u_mem.mem[0] = 32'hA000_00AA;
    dut.u_mem.mem[1] = 32'h1111_0001;
    dut.u_mem.mem[2] = 32'h2222_0002;
    dut.u_mem.mem[5] = 32'h5555_0005;

    rst = 1'b1; stall = 1'b0; pc_src = 1'b0; branch_target = '0;
    #1;

    // 1. Reset release
    step(); chk_all("rst1", 32'h0, 32'h0, 32'h0, 1'b0);
    step(); chk_all("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    step(); chk_all("rel1", 32'h4, 32'hA000_00AA, 32'h4, 1'b1);
    step(); chk_all("rel2", 32'h8, 32'h1111_0001, 32'h8, 1'b1);

    // 2. Sequential run of 4 cycles from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    step(); chk_all("seq0", 32'h4,  32'hA000_00AA, 32'h4,  1'b1);
    step(); chk_all("seq1", 32'h8,  32'h1111_0001, 32'h8,  1'b1);
    step(); chk_all("seq2", 32'hC,  32'h2222_0002, 32'hC,  1'b1);
    step(); chk_all("seq3", 32'h10, 32'h0000_0000, 32'h10, 1'b1);

    // 3. Stall for 3 cycles after 11110001 is output
    rst = 1'b1; step(); rst = 1'b0;
    step(); step(); chk_all("pre_stall", 32'h8, 32'h1111_0001, 32'h8, 1'b1);
    stall = 1'b1;
    step(); chk_all("stall1", 32'h8, 32'h1111_0001, 32'h8, 1'b1);
    step(); chk_all("stall2", 32'h8, 32'h1111_0001, 32'h8, 1'b1);
    step(); chk_all("stall3", 32'h8, 32'h1111_0001, 32'h8, 1'b1);
    stall = 1'b0;
    step(); chk_all("unstall", 32'hC, 32'h2222_0002, 32'hC, 1'b1);

    // 4. Redirect to a misaligned target
    pc_src = 1'b1; branch_target = 32'h16;
    step(); chk_all("redir_bub", 32'h14, 32'h0, 32'h0, 1'b0);
    pc_src = 1'b0; branch_target = 32'h0;
    step(); chk_all("redir_tgt", 32'h18, 32'h5555_0005, 32'h18, 1'b1);

    // 5. Redirect during stall, two branches (last wins)
    stall = 1'b1; pc_src = 1'b1; branch_target = 32'h8;
    step(); chk_all("sred1", 32'h18, 32'h5555_0005, 32'h18, 1'b1);
    branch_target = 32'h14;
    step(); chk_all("sred2", 32'h18, 32'h5555_0005, 32'h18, 1'b1);
    pc_src = 1'b0; branch_target = 32'h0;
    step(); chk_all("sred3", 32'h18, 32'h5555_0005, 32'h18, 1'b1);
    stall = 1'b0;
    step(); chk_all("sred_bub", 32'h14, 32'h0, 32'h0, 1'b0);
    step(); chk_all("sred_tgt", 32'h18, 32'h5555_0005, 32'h18, 1'b1);

    // 6. Reset with a redirect pending
    stall = 1'b1; pc_src = 1'b1; branch_target = 32'h14;
    step(); chk_all("pend", 32'h18, 32'h5555_0005, 32'h18, 1'b1);
    stall = 1'b0; pc_src = 1'b0; branch_target = 32'h0; rst = 1'b1;
    step(); chk_all("rst_pend", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    step(); chk_all("rst_resume", 32'h4, 32'hA000_00AA, 32'h4, 1'b1);

    // Index wraps modulo depth: 0x204 -> word 129 -> mem[1]
    pc_src = 1'b1; branch_target = 32'h204;
    step(); chk_all("wrap_bub", 32'h204, 32'h0, 32'h0, 1'b0);
    pc_src = 1'b0;
    step(); chk_all("wrap_idx", 32'h208, 32'h1111_0001, 32'h208, 1'b1);

    // PC+4 wraps at 2^32
    pc_src = 1'b1; branch_target = 32'hFFFF_FFFF;
    step(); chk_all("top_bub", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    pc_src = 1'b0;
    step(); chk_all("top_wrap", 32'h0, 32'h0, 32'h0, 1'b1);
    step(); chk_all("top_next", 32'h4, 32'hA000_00AA, 32'h4, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
